rc5_key_expand: RTL and testbench

RC5_KEY_EXPAND -- requirements
Module: rc5_key_expand

---
 rtl/rc5_pkg.sv | 47 ++++
 rtl/rc5_key_expand_rotl.sv | 13 +
 rtl/rc5_key_expand.sv | 183 ++++++++++++++++++
 tb/tb_rc5_key_expand.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc5_pkg.sv
// Shared RC5 definitions: word geometry, magic constants, FSM encodings and
// small helpers for sizing the key-expansion run.
package rc5_pkg;

  localparam int W      = 16;   // word width
  localparam int C      = 8;    // key words (128-bit key)
  localparam int MAX_T  = 34;   // subkey table depth (16 rounds)
  localparam int MAX_R  = 16;   // largest supported round count
  localparam int IDX_W  = 6;    // table index / table length width
  localparam int CNT_W  = 7;    // mix counter width (n <= 102)
  localparam int J_W    = 3;    // key word index width
  localparam int ROT_W  = 4;    // rotate amount width (mod 16)

  localparam logic [W-1:0] P16 = 16'hB7E1;
  localparam logic [W-1:0] Q16 = 16'h9E37;

  // Key expansion controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    MIX  = 2'd2,
    DONE = 2'd3
  } kx_state_t;

  // Encrypt/decrypt core states
  typedef enum logic [1:0] {
    CORE_IDLE  = 2'd0,
    CORE_PRE   = 2'd1,
    CORE_ROUND = 2'd2,
    CORE_OUT   = 2'd3
  } core_state_t;

  // Table length t = 2*(min(r,16)+1)
  function automatic logic [IDX_W-1:0] calc_t(input logic [4:0] r);
    logic [IDX_W-1:0] r_eff;
    r_eff = (r > 5'(MAX_R)) ? IDX_W'(MAX_R) : IDX_W'(r);
    return (r_eff + IDX_W'(1)) << 1;
  endfunction

  // Mix iteration count n = 3*max(t, C)
  function automatic logic [CNT_W-1:0] calc_n(input logic [IDX_W-1:0] t);
    logic [CNT_W-1:0] base;
    base = (t < IDX_W'(C)) ? CNT_W'(C) : CNT_W'(t);
    return base + base + base;
  endfunction

endpackage

// File: rtl/rc5_key_expand_rotl.sv
// 16-bit rotate-left by a 4-bit amount (rotation taken mod 16).
module rotl
  import rc5_pkg::*;
(
  input  logic [W-1:0]     data_i,
  input  logic [ROT_W-1:0] n_i,
  output logic [W-1:0]     data_o
);

  // A zero amount shifts the right-hand term out completely, leaving data_i.
  assign data_o = (data_i << n_i) | (data_i >> (5'(W) - {1'b0, n_i}));

endmodule

// File: rtl/rc5_key_expand.sv
// RC5-16 key schedule: fills the subkey table S[0..t-1] with the magic
// sequence, then mixes the secret key in, one table write per cycle.
module rc5_key_expand
  import rc5_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       num_rounds,
  input  logic [C*W-1:0]   key,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [W-1:0]     rd_key,
  output logic             busy,
  output logic             done,
  output logic             keys_valid
);

  kx_state_t        state_reg, state_next;
  logic [W-1:0]     s_reg [MAX_T];
  logic [W-1:0]     l_reg [C];
  logic [W-1:0]     a_reg, a_next;
  logic [W-1:0]     b_reg, b_next;
  logic [W-1:0]     init_reg, init_next;
  logic [IDX_W-1:0] i_reg, i_next;
  logic [J_W-1:0]   j_reg, j_next;
  logic [CNT_W-1:0] k_reg, k_next;
  logic [IDX_W-1:0] t_reg, t_next;
  logic [CNT_W-1:0] n_reg, n_next;
  logic             kv_reg, kv_next;

  logic             s_we;
  logic [W-1:0]     s_wdata;
  logic             l_load;
  logic             l_we;
  logic [MAX_T-1:0] s_sel;
  logic [C-1:0]     l_sel;

  logic [W-1:0]     sum_a, a_mix, sum_b, ab_sum, b_mix;

  // Mixing datapath: both rotations evaluated from current state each cycle.
  assign sum_a  = s_reg[i_reg] + a_reg + b_reg;
  assign sum_b  = l_reg[j_reg] + a_mix + b_reg;
  assign ab_sum = a_mix + b_reg;

  rotl u_rot_const (
    .data_i (sum_a),
    .n_i    (ROT_W'(3)),
    .data_o (a_mix)
  );

  rotl u_rot_var (
    .data_i (sum_b),
    .n_i    (ab_sum[ROT_W-1:0]),
    .data_o (b_mix)
  );

  // Per-entry write enables; S is always written at i, L at j.
  generate
    for (genvar gi = 0; gi < MAX_T; gi++) begin : g_s_sel
      assign s_sel[gi] = s_we && (i_reg == IDX_W'(gi));
    end
    for (genvar gi = 0; gi < C; gi++) begin : g_l_sel
      assign l_sel[gi] = l_we && (j_reg == J_W'(gi));
    end
  endgenerate

  assign rd_key     = (rd_idx < IDX_W'(MAX_T)) ? s_reg[rd_idx] : '0;
  assign keys_valid = kv_reg;

  // Next-state, datapath control and status outputs.
  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    init_next  = init_reg;
    i_next     = i_reg;
    j_next     = j_reg;
    k_next     = k_reg;
    t_next     = t_reg;
    n_next     = n_reg;
    kv_next    = kv_reg;
    s_we       = 1'b0;
    s_wdata    = init_reg;
    l_load     = 1'b0;
    l_we       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = INIT;
          t_next     = calc_t(num_rounds);
          n_next     = calc_n(calc_t(num_rounds));
          kv_next    = 1'b0;
          a_next     = '0;
          b_next     = '0;
          i_next     = '0;
          j_next     = '0;
          k_next     = '0;
          init_next  = P16;
          l_load     = 1'b1;
        end
      end
      INIT: begin
        busy      = 1'b1;
        s_we      = 1'b1;
        s_wdata   = init_reg;
        init_next = init_reg + Q16;
        if (i_reg == t_reg - IDX_W'(1)) begin
          i_next     = '0;
          state_next = MIX;
        end else begin
          i_next = i_reg + IDX_W'(1);
        end
      end
      MIX: begin
        busy    = 1'b1;
        s_we    = 1'b1;
        s_wdata = a_mix;
        l_we    = 1'b1;
        a_next  = a_mix;
        b_next  = b_mix;
        i_next  = (i_reg == t_reg - IDX_W'(1)) ? '0 : i_reg + IDX_W'(1);
        j_next  = j_reg + J_W'(1);
        if (k_reg == n_reg - CNT_W'(1)) begin
          state_next = DONE;
          kv_next    = 1'b1;
        end else begin
          k_next = k_reg + CNT_W'(1);
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Control and scalar state registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      init_reg  <= '0;
      i_reg     <= '0;
      j_reg     <= '0;
      k_reg     <= '0;
      t_reg     <= '0;
      n_reg     <= '0;
      kv_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      init_reg  <= init_next;
      i_reg     <= i_next;
      j_reg     <= j_next;
      k_reg     <= k_next;
      t_reg     <= t_next;
      n_reg     <= n_next;
      kv_reg    <= kv_next;
    end
  end

  // Subkey table S and key words L; entries beyond t are never selected.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int m = 0; m < MAX_T; m++) s_reg[m] <= '0;
      for (int m = 0; m < C; m++)     l_reg[m] <= '0;
    end else begin
      for (int m = 0; m < MAX_T; m++) begin
        if (s_sel[m]) s_reg[m] <= s_wdata;
      end
      for (int m = 0; m < C; m++) begin
        if (l_load)      l_reg[m] <= key[m*W +: W];
        else if (l_sel[m]) l_reg[m] <= b_mix;
      end
    end
  end

endmodule

// File: tb/tb_rc5_key_expand.sv
// Self-checking bench for rc5_key_expand against a plain RC5-16 key-schedule
// model, with an RC5-16/12 encrypt/decrypt round trip on the produced table.
module tb_rc5_key_expand;

  typedef logic [15:0] tab_t [34];

  logic         clk;
  logic         rst;
  logic         start;
  logic [4:0]   num_rounds;
  logic [127:0] key;
  logic [5:0]   rd_idx;
  logic [15:0]  rd_key;
  logic         busy;
  logic         done;
  logic         keys_valid;

  int   checks = 0;
  int   errors = 0;
  tab_t exp_tab;

  rc5_key_expand dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_rounds (num_rounds),
    .key        (key),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] rotl16(input logic [15:0] x, input int n);
    logic [31:0] d;
    d = {x, x} << n;
    return d[31:16];
  endfunction

  function automatic logic [15:0] rotr16(input logic [15:0] x, input int n);
    return rotl16(x, (16 - n) % 16);
  endfunction

  function automatic int exp_t(input logic [4:0] r);
    int re;
    re = (r > 16) ? 16 : int'(r);
    return 2 * (re + 1);
  endfunction

  // Reference key schedule; S[t..33] keep whatever the table held before.
  function automatic void model(input logic [127:0] k, input logic [4:0] r);
    logic [15:0] l [8];
    logic [15:0] a, b, s;
    int t, n, ii, jj;
    t = exp_t(r);
    n = 3 * ((t > 8) ? t : 8);
    for (int m = 0; m < 8; m++) l[m] = k[16*m +: 16];
    exp_tab[0] = 16'hB7E1;
    for (int m = 1; m < t; m++) exp_tab[m] = exp_tab[m-1] + 16'h9E37;
    a = 0; b = 0; ii = 0; jj = 0;
    for (int c = 0; c < n; c++) begin
      s = exp_tab[ii] + a + b;
      a = rotl16(s, 3);
      exp_tab[ii] = a;
      s = a + b;
      b = rotl16(l[jj] + a + b, int'(s[3:0]));
      l[jj] = b;
      ii = (ii + 1) % t;
      jj = (jj + 1) % 8;
    end
  endfunction

  function automatic logic [31:0] rc5_enc(input logic [31:0] pt, input tab_t s, input int r);
    logic [15:0] a, b;
    a = pt[15:0] + s[0];
    b = pt[31:16] + s[1];
    for (int i = 1; i <= r; i++) begin
      a = rotl16(a ^ b, int'(b[3:0])) + s[2*i];
      b = rotl16(b ^ a, int'(a[3:0])) + s[2*i+1];
    end
    return {b, a};
  endfunction

  function automatic logic [31:0] rc5_dec(input logic [31:0] ct, input tab_t s, input int r);
    logic [15:0] a, b;
    a = ct[15:0];
    b = ct[31:16];
    for (int i = r; i >= 1; i--) begin
      b = rotr16(b - s[2*i+1], int'(a[3:0])) ^ a;
      a = rotr16(a - s[2*i], int'(b[3:0])) ^ b;
    end
    b = b - s[1];
    a = a - s[0];
    return {b, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input int idx, output logic [15:0] v);
    rd_idx = 6'(idx);
    #1;
    v = rd_key;
  endtask

  task automatic chk_table(input string tag);
    logic [15:0] v;
    for (int m = 0; m < 34; m++) begin
      rd(m, v);
      chk($sformatf("%s_s%0d", tag, m), {16'h0, v}, {16'h0, exp_tab[m]});
    end
    rd(34, v);
    chk($sformatf("%s_oob34", tag), {16'h0, v}, 32'h0);
    rd(63, v);
    chk($sformatf("%s_oob63", tag), {16'h0, v}, 32'h0);
  endtask

  // One expansion run. Cycle 0 ends with the start edge; samples are taken
  // on the falling edge inside each cycle. Optional second start / reset.
  task automatic run(input logic [127:0] k, input logic [4:0] r,
                     input int inj_cyc, input logic [127:0] k2,
                     input int rst_cyc, input bit probe,
                     output int done_cyc, output int done_cnt,
                     output int busy_err, output int kv_err);
    int t, n, last;
    logic [15:0] v;
    t = exp_t(r);
    n = 3 * ((t > 8) ? t : 8);
    last = (rst_cyc > 0 && rst_cyc < t + n) ? rst_cyc : t + n;
    done_cyc = -1; done_cnt = 0; busy_err = 0; kv_err = 0;
    @(negedge clk);
    key = k; num_rounds = r; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    key = {$urandom(), $urandom(), $urandom(), $urandom()};
    num_rounds = 5'($urandom_range(31));
    for (int cyc = 1; cyc <= t + n + 3; cyc++) begin
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (busy !== (cyc <= last)) busy_err++;
      if (keys_valid !== (rst_cyc == 0 && cyc > t + n)) kv_err++;
      if (probe && cyc == 27) begin
        rd(0, v); chk("init_s0", {16'h0, v}, 32'hB7E1);
        rd(1, v); chk("init_s1", {16'h0, v}, 32'h5618);
        rd(2, v); chk("init_s2", {16'h0, v}, 32'hF44F);
      end
      if (probe && cyc == 28) begin
        rd(0, v); chk("mix1_s0", {16'h0, v}, 32'hBF0D);
      end
      if (cyc == inj_cyc) begin
        start = 1'b1; key = k2; num_rounds = 5'd0;
      end
      if (cyc == inj_cyc + 1) start = 1'b0;
      if (cyc == rst_cyc) rst = 1'b0;
      if (cyc == rst_cyc + 1) rst = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [127:0] k1, k2;
    logic [15:0]  v;
    int           dc, dn, be, ke;
    int           rlist [5];
    tab_t         dt;
    logic [31:0]  ct_d, ct_m;

    rlist = '{16, 0, 1, 12, 20};
    rst = 1'b0; start = 1'b0; key = '0; num_rounds = '0; rd_idx = '0;
    for (int m = 0; m < 34; m++) exp_tab[m] = 16'h0;

    // Reset state, and reset winning over start on the same edge
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_kv", {31'h0, keys_valid}, 32'h0);
    rd(0, v);  chk("rst_s0", {16'h0, v}, 32'h0);
    rd(33, v); chk("rst_s33", {16'h0, v}, 32'h0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rst_over_start", {31'h0, busy}, 32'h0);

    // Zero key, r = 12, with mid-run probes and a round trip
    model(128'h0, 5'd12);
    run(128'h0, 5'd12, 0, 128'h0, 0, 1'b1, dc, dn, be, ke);
    $display("run key=0 r=12 done_cyc=%0d pulses=%0d", dc, dn);
    chk("r12_done_cyc", dc, 105);
    chk("r12_done_cnt", dn, 1);
    chk("r12_busy", be, 0);
    chk("r12_kv", ke, 0);
    chk_table("r12z");
    for (int m = 0; m < 34; m++) rd(m, dt[m]);
    ct_d = rc5_enc(32'h1234_5678, dt, 12);
    ct_m = rc5_enc(32'h1234_5678, exp_tab, 12);
    chk("enc_ct", ct_d, ct_m);
    chk("round_trip", rc5_dec(ct_d, dt, 12), 32'h1234_5678);

    // Random keys across round counts; r = 20 saturates to 16
    foreach (rlist[x]) begin
      k1 = {$urandom(), $urandom(), $urandom(), $urandom()};
      model(k1, 5'(rlist[x]));
      run(k1, 5'(rlist[x]), 0, 128'h0, 0, 1'b0, dc, dn, be, ke);
      $display("run key=%h r=%0d done_cyc=%0d pulses=%0d", k1, rlist[x], dc, dn);
      chk($sformatf("r%0d_done_cyc", rlist[x]), dc, exp_t(5'(rlist[x])) + 3 * ((exp_t(5'(rlist[x])) > 8) ? exp_t(5'(rlist[x])) : 8) + 1);
      chk($sformatf("r%0d_done_cnt", rlist[x]), dn, 1);
      chk($sformatf("r%0d_busy", rlist[x]), be, 0);
      chk($sformatf("r%0d_kv", rlist[x]), ke, 0);
      chk_table($sformatf("rnd_r%0d", rlist[x]));
    end

    // Second start with another key at cycle 40 must be ignored
    k1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    k2 = ~k1;
    model(k1, 5'd12);
    run(k1, 5'd12, 40, k2, 0, 1'b0, dc, dn, be, ke);
    $display("run key=%h r=12 restart@40 done_cyc=%0d pulses=%0d", k1, dc, dn);
    chk("inj_done_cyc", dc, 105);
    chk("inj_done_cnt", dn, 1);
    chk("inj_busy", be, 0);
    chk("inj_kv", ke, 0);
    chk_table("inj");

    // Reset at cycle 50 aborts the run and clears the table
    k1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    run(k1, 5'd12, 0, 128'h0, 50, 1'b0, dc, dn, be, ke);
    $display("run key=%h r=12 reset@50 pulses=%0d", k1, dn);
    for (int m = 0; m < 34; m++) exp_tab[m] = 16'h0;
    chk("abort_done_cnt", dn, 0);
    chk("abort_busy", be, 0);
    chk("abort_kv", ke, 0);
    chk_table("abort");

    // A fresh run after the abort completes normally
    k1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    model(k1, 5'd12);
    run(k1, 5'd12, 0, 128'h0, 0, 1'b0, dc, dn, be, ke);
    $display("run key=%h r=12 after-abort done_cyc=%0d pulses=%0d", k1, dc, dn);
    chk("post_done_cyc", dc, 105);
    chk("post_done_cnt", dn, 1);
    chk("post_busy", be, 0);
    chk("post_kv", ke, 0);
    chk_table("post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
